// File: rtl/enc_pkg.sv
// Shared types and helpers for the encoder step tracker.
//   ch_state_e : per-channel state (ST_PRIME waits for its first sample, ST_RUN computes deltas)
//   sat_res_t  : result of a saturating add (clamped value plus clamp flag)
//   acc_max()  : largest accumulator magnitude for a given accumulator width
//   half()     : the ambiguous half-turn delta for a given position width
package enc_pkg;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } ch_state_e;

  // Values for the default configuration (WIDTH=5, ACC_W=6).
  localparam int WIDTH_DEF = 5;
  localparam int ACC_W_DEF = 6;
  localparam int ACC_MAX   = 2 ** (ACC_W_DEF - 1) - 1;
  localparam int HALF      = 2 ** (WIDTH_DEF - 1);

  typedef struct packed {
    logic        clamped;
    logic [31:0] value;
  } sat_res_t;

  function automatic int acc_max(input int acc_w);
    return (1 << (acc_w - 1)) - 1;
  endfunction

  function automatic int half(input int width);
    return 1 << (width - 1);
  endfunction

  // Signed a + b clamped to [-lim, +lim]; clamped flags any limiting.
  function automatic sat_res_t sat_add(input int a, input int b, input int lim);
    sat_res_t r;
    int s;
    s = a + b;
    r.clamped = 1'b0;
    r.value   = 32'(s);
    if (s > lim) begin
      r.clamped = 1'b1;
      r.value   = 32'(lim);
    end else if (s < -lim) begin
      r.clamped = 1'b1;
      r.value   = 32'(-lim);
    end
    return r;
  endfunction

endpackage

// File: rtl/enc_step_channel.sv
// One encoder channel: wrap-aware delta, deadband, saturating pending-step
// accumulator and rate-limited inc/dec pulse replay.
// Ports:
//   clk, reset (async, active-low)
//   sample_en : pos is sampled on cycles where this is 1
//   clear     : synchronous drop of pending steps and ovf, back to ST_PRIME
//   pos       : absolute position, wraps mod 2^WIDTH
//   inc, dec  : registered 1-cycle pulses, one per count
//   busy      : accumulator non-zero
//   ovf       : sticky saturation flag
//   state     : current channel state (debug visibility)
module enc_step_channel
  import enc_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int DEADBAND  = 0,
  parameter int ACC_W     = 6,
  parameter int PULSE_GAP = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic             clear,
  input  logic [WIDTH-1:0] pos,
  output logic             inc,
  output logic             dec,
  output logic             busy,
  output logic             ovf,
  output ch_state_e        state
);

  localparam int GAP_W = (PULSE_GAP > 0) ? $clog2(PULSE_GAP + 1) : 1;
  localparam int LIM   = acc_max(ACC_W);
  localparam logic [WIDTH-1:0] HALF_PAT = WIDTH'(half(WIDTH));

  ch_state_e               state_q, state_d;
  logic [WIDTH-1:0]        prev_q, prev_d, diff;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic                    inc_q, inc_d, dec_q, dec_d;
  logic                    busy_q, busy_d, ovf_q, ovf_d;
  logic                    emit;
  int                      d_int, d_mag, d_add, sgn;
  sat_res_t                res;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    diff    = pos - prev_q;
    d_int   = int'($signed(diff));
    d_mag   = (d_int < 0) ? -d_int : d_int;
    d_add   = 0;
    emit    = (acc_q != '0) && (gap_q == '0);
    sgn     = emit ? (acc_q[ACC_W-1] ? -1 : 1) : 0;

    if (sample_en) begin
      if (state_q == ST_PRIME) begin
        prev_d  = pos;
        state_d = ST_RUN;
      end else if (diff == HALF_PAT) begin
        // Half-turn jump has no defined direction: resync only.
        prev_d = pos;
      end else if (d_mag > DEADBAND) begin
        prev_d = pos;
        d_add  = d_int;
      end
      // Inside the deadband prev is held so slow creep still builds up.
    end

    // Emission and a new step on the same edge combine arithmetically.
    res    = sat_add(int'(acc_q), d_add - sgn, LIM);
    acc_d  = res.value[ACC_W-1:0];
    ovf_d  = ovf_q | res.clamped;
    busy_d = (acc_d != '0);
    inc_d  = emit & ~acc_q[ACC_W-1];
    dec_d  = emit & acc_q[ACC_W-1];
    if (emit) begin
      gap_d = GAP_W'(PULSE_GAP);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GAP_W'(1);
    end else begin
      gap_d = gap_q;
    end

    if (clear) begin
      state_d = ST_PRIME;
      prev_d  = prev_q;
      acc_d   = '0;
      gap_d   = '0;
      inc_d   = 1'b0;
      dec_d   = 1'b0;
      busy_d  = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_PRIME;
      prev_q  <= '0;
      acc_q   <= '0;
      gap_q   <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      acc_q   <= acc_d;
      gap_q   <= gap_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign inc   = inc_q;
  assign dec   = dec_q;
  assign busy  = busy_q;
  assign ovf   = ovf_q;
  assign state = state_q;

endmodule

// File: rtl/enc_step_tracker.sv
// Multi-channel encoder step tracker: turns debounced absolute positions into
// one inc/dec pulse per count for the cursor counters.
// Ports:
//   clk, reset (async, active-low)
//   sample_en, clear : shared by all channels
//   enc_pos          : channel c at [c*WIDTH +: WIDTH]
//   inc, dec         : per-channel 1-cycle count pulses
//   busy             : per-channel pulses still pending
//   ovf              : per-channel sticky saturation flag
//   state            : per-channel debug, 1 = channel primed and running
module enc_step_tracker
  import enc_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int WIDTH     = 5,
  parameter int DEADBAND  = 0,
  parameter int ACC_W     = 6,
  parameter int PULSE_GAP = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic                 clear,
  input  logic [NCH*WIDTH-1:0] enc_pos,
  output logic [NCH-1:0]       inc,
  output logic [NCH-1:0]       dec,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       ovf,
  output logic [NCH-1:0]       state
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    ch_state_e ch_state;

    enc_step_channel #(
      .WIDTH    (WIDTH),
      .DEADBAND (DEADBAND),
      .ACC_W    (ACC_W),
      .PULSE_GAP(PULSE_GAP)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .sample_en(sample_en),
      .clear    (clear),
      .pos      (enc_pos[c*WIDTH +: WIDTH]),
      .inc      (inc[c]),
      .dec      (dec[c]),
      .busy     (busy[c]),
      .ovf      (ovf[c]),
      .state    (ch_state)
    );

    assign state[c] = (ch_state == ST_RUN);
  end

endmodule

// File: tb/tb_enc_step_tracker.sv
// Bench for enc_step_tracker. Two instances share stimulus: dut_a uses the
// default parameters, dut_b uses DEADBAND=1, ACC_W=4, PULSE_GAP=2.
module tb_enc_step_tracker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_en = 1'b0;
  logic       clear = 1'b0;
  logic [9:0] enc_pos = '0;

  logic [1:0] inc_a, dec_a, busy_a, ovf_a, st_a;
  logic [1:0] inc_b, dec_b, busy_b, ovf_b, st_b;
  logic [1:0] inc_v[2], dec_v[2], busy_v[2], ovf_v[2];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Expected pulse tag: [31] dut, [30] channel, [29] inc, [28] both, [19:0] cycle.
  logic [31:0] exp_q[$];

  // Reference model state, indexed [dut][channel].
  int m_acc[2][2], m_gap[2][2], m_ovf[2][2], m_prev[2][2], m_prim[2][2];

  always #5 clk = ~clk;

  enc_step_tracker dut_a (
    .clk(clk), .reset(reset), .sample_en(sample_en), .clear(clear), .enc_pos(enc_pos),
    .inc(inc_a), .dec(dec_a), .busy(busy_a), .ovf(ovf_a), .state(st_a)
  );

  enc_step_tracker #(.DEADBAND(1), .ACC_W(4), .PULSE_GAP(2)) dut_b (
    .clk(clk), .reset(reset), .sample_en(sample_en), .clear(clear), .enc_pos(enc_pos),
    .inc(inc_b), .dec(dec_b), .busy(busy_b), .ovf(ovf_b), .state(st_b)
  );

  assign inc_v[0] = inc_a;   assign inc_v[1] = inc_b;
  assign dec_v[0] = dec_a;   assign dec_v[1] = dec_b;
  assign busy_v[0] = busy_a; assign busy_v[1] = busy_b;
  assign ovf_v[0] = ovf_a;   assign ovf_v[1] = ovf_b;

  function automatic int p_db(input int d);  return d ? 1 : 0; endfunction
  function automatic int p_lim(input int d); return d ? 7 : 31; endfunction
  function automatic int p_gap(input int d); return d ? 2 : 0; endfunction

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: pending count, spacing countdown and sticky overflow per channel.
  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        int pos, delta, add, dir, nxt;
        bit emit;
        pos = int'((enc_pos >> (c * 5)) & 10'd31);
        if (!reset || clear) begin
          m_acc[d][c] = 0; m_gap[d][c] = 0; m_ovf[d][c] = 0; m_prim[d][c] = 0;
          if (!reset) m_prev[d][c] = 0;
        end else begin
          emit = (m_acc[d][c] != 0) && (m_gap[d][c] == 0);
          dir = emit ? ((m_acc[d][c] > 0) ? 1 : -1) : 0;
          add = 0;
          if (sample_en) begin
            if (m_prim[d][c] == 0) begin
              m_prim[d][c] = 1;
              m_prev[d][c] = pos;
            end else begin
              delta = (pos - m_prev[d][c] + 32) % 32;
              if (delta >= 16) delta -= 32;
              if (delta == -16) m_prev[d][c] = pos;
              else if (delta > p_db(d) || delta < -p_db(d)) begin
                m_prev[d][c] = pos;
                add = delta;
              end
            end
          end
          nxt = m_acc[d][c] + add - dir;
          if (nxt > p_lim(d)) begin nxt = p_lim(d); m_ovf[d][c] = 1; end
          if (nxt < -p_lim(d)) begin nxt = -p_lim(d); m_ovf[d][c] = 1; end
          m_acc[d][c] = nxt;
          if (emit) m_gap[d][c] = p_gap(d);
          else if (m_gap[d][c] > 0) m_gap[d][c] = m_gap[d][c] - 1;
          if (emit) exp_q.push_back({d[0], c[0], (dir > 0), 9'd0, cyc[19:0]});
        end
      end
    end
  end

  // Monitor: pop an expectation for every pulse the DUTs present.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        logic pi, pd;
        logic [31:0] got, exp;
        pi = inc_v[d][c];
        pd = dec_v[d][c];
        if (pi || pd) begin
          got = {d[0], c[0], pi, (pi & pd), 8'd0, cyc[19:0]};
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL pulse: dut %0d ch %0d got tag %h, no pulse expected", d, c, got);
          end else begin
            exp = exp_q.pop_front();
            if (got != exp) begin
              fails++;
              $display("FAIL pulse: dut %0d ch %0d got tag %h expected %h", d, c, got, exp);
            end
          end
        end
        chk($sformatf("busy d%0d c%0d", d, c), int'(busy_v[d][c]), int'(m_acc[d][c] != 0));
        chk($sformatf("ovf d%0d c%0d", d, c), int'(ovf_v[d][c]), m_ovf[d][c]);
      end
    end
    while (exp_q.size() > 0 && exp_q[0][19:0] <= cyc[19:0]) begin
      tests++;
      fails++;
      $display("FAIL missed pulse: expected tag %h not observed (cycle %0d)", exp_q[0], cyc);
      void'(exp_q.pop_front());
    end
  end

  task automatic step(input logic en, input logic clr, input int x, input int y);
    @(negedge clk); #1;
    sample_en = en;
    clear = clr;
    enc_pos = {5'(y), 5'(x)};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      sample_en = 1'b0;
      clear = 1'b0;
    end
  endtask

  initial begin
    int x, y;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    chk("reset inc_a", int'(inc_a), 0);
    chk("reset busy_b", int'(busy_b), 0);
    chk("reset state_a", int'(st_a), 0);

    // Single count, wrap both ways, ambiguous half turn.
    step(1, 0, 10, 0); step(1, 0, 11, 0); idle(4);
    step(1, 0, 31, 0); idle(30);
    step(1, 0, 0, 0);  idle(6);
    step(1, 0, 31, 0); idle(6);
    step(1, 0, 0, 0);  idle(6);
    step(1, 0, 16, 0); idle(6);
    // Multi-count burst, deadband creep, Y channel activity.
    step(1, 0, 4, 5);  idle(30);
    step(1, 0, 9, 5);  idle(20);
    step(1, 0, 10, 6); idle(6);
    step(1, 0, 11, 8); idle(10);
    step(1, 0, 12, 8); idle(10);
    // Back-to-back +7 jumps saturate dut_b, then clear.
    step(1, 0, 0, 0);  idle(40);
    step(1, 0, 7, 0);  step(1, 0, 14, 0); idle(2);
    step(0, 1, 14, 0); idle(10);
    step(1, 0, 20, 0); idle(6);
    chk("primed state_a", int'(st_a), 3);

    // Asynchronous reset mid-burst.
    step(1, 0, 4, 0);  idle(40);
    step(1, 0, 9, 0);  idle(2);
    @(negedge clk); #1 reset = 1'b0;
    #1;
    chk("async inc_a", int'(inc_a), 0);
    chk("async dec_a", int'(dec_a), 0);
    chk("async busy_a", int'(busy_a), 0);
    chk("async busy_b", int'(busy_b), 0);
    chk("async state_b", int'(st_b), 0);
    idle(2);
    @(negedge clk); #1 reset = 1'b1;
    step(1, 0, 20, 3); idle(6);

    // Randomized traffic.
    x = 20; y = 3;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) x = int'($urandom_range(0, 31));
      else x = (x + int'($urandom_range(0, 6)) - 3) & 31;
      if ($urandom_range(0, 3) == 0) y = int'($urandom_range(0, 31));
      else y = (y + int'($urandom_range(0, 6)) - 3) & 31;
      step($urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0, x, y);
    end
    idle(60);
    @(negedge clk); #2;
    chk("queue drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
